// File: rtl/pulse_window_counter.sv
// Purpose : counts detector pulses over fixed WINDOW-cycle windows and reports each completed window's count plus a threshold flag.
// Latency : a window starts on the edge that samples en high in IDLE; count_valid is high in the cycle after the WINDOW-th following edge, so reports repeat every WINDOW+1 cycles.
// Backpres: none; pulses are never stalled; dropping en discards the partial window, and pulses in IDLE or REPORT are ignored.
//
// Ports:
//   clk          single clock, all state updates on posedge
//   reset        synchronous active-high reset, dominates en and pulse
//   en           starts and sustains windowed counting
//   pulse        event input, one event per cycle it is high
//   count        count of the last completed window (held between reports)
//   count_valid  one-cycle strobe, count/over are new in this cycle
//   over         last completed window count >= THRESH (held between reports)
module pulse_window_counter #(
    parameter int WINDOW = 16,
    parameter int CW     = 8,
    parameter int THRESH = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          pulse,
    output logic [CW-1:0] count,
    output logic          count_valid,
    output logic          over
);

    localparam int            WW       = $clog2(WINDOW);
    localparam logic [WW-1:0] WLAST    = WW'(WINDOW - 1);
    localparam logic [CW-1:0] ACC_MAX  = {CW{1'b1}};
    localparam logic [CW-1:0] THRESH_C = CW'(THRESH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [WW-1:0] wcnt_q,  wcnt_d;
    logic [CW-1:0] acc_q,   acc_d;
    logic [CW-1:0] count_q, count_d;
    logic          over_q,  over_d;
    logic          vld_q,   vld_d;

    // Accumulator including this cycle's pulse; saturates at all-ones so a
    // burst of pulses can never wrap the count back to a small value.
    logic [CW-1:0] acc_inc;
    assign acc_inc = (pulse && (acc_q != ACC_MAX)) ? (acc_q + CW'(1)) : acc_q;

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        acc_d   = acc_q;
        count_d = count_q;
        over_d  = over_q;
        vld_d   = 1'b0;
        case (state_q)
            IDLE: begin
                acc_d  = '0;
                wcnt_d = '0;
                if (en) begin
                    state_d = COUNT;
                end
            end
            COUNT: begin
                if (!en) begin
                    // Partial window is thrown away; report registers keep
                    // the last completed window.
                    state_d = IDLE;
                    acc_d   = '0;
                    wcnt_d  = '0;
                end else if (wcnt_q == WLAST) begin
                    // Final cycle of the window: its pulse is part of the report.
                    state_d = REPORT;
                    acc_d   = '0;
                    wcnt_d  = '0;
                    count_d = acc_inc;
                    over_d  = (acc_inc >= THRESH_C);
                    vld_d   = 1'b1;
                end else begin
                    acc_d  = acc_inc;
                    wcnt_d = wcnt_q + WW'(1);
                end
            end
            REPORT: begin
                // Pulses in the report cycle belong to no window.
                acc_d   = '0;
                wcnt_d  = '0;
                state_d = en ? COUNT : IDLE;
            end
            default: begin
                state_d = IDLE;
                acc_d   = '0;
                wcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            acc_q   <= '0;
            count_q <= '0;
            over_q  <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            over_q  <= over_d;
            vld_q   <= vld_d;
        end
    end

    assign count       = count_q;
    assign count_valid = vld_q;
    assign over        = over_q;

endmodule
